// File: rtl/pipeimem_loader_pkg.sv
// Purpose: shared constants for the imem loader (FSM encodings, default imem width).
// Latency: n/a (package).
// Backpressure: n/a (package).
package pipeimem_loader_pkg;

  // Default imem word-address width (64 words).
  localparam int IMEM_AW = 6;

  // Loader FSM encodings.
  localparam logic [1:0] LD_IDLE  = 2'd0;
  localparam logic [1:0] LD_RECV  = 2'd1;
  localparam logic [1:0] LD_WRITE = 2'd2;
  localparam logic [1:0] LD_DONE  = 2'd3;

  // A load is in flight while receiving bytes or writing a word.
  function automatic logic ld_busy(input logic [1:0] st);
    return (st == LD_RECV) || (st == LD_WRITE);
  endfunction

endpackage

// File: rtl/pipeimem_loader_byte_packer.sv
// Purpose: packs a byte stream into a little-endian 32-bit word (first byte -> [7:0]).
// Latency: byte lands in word one cycle after shift_en; last is combinational from idx.
// Backpressure: none; the caller only asserts shift_en when a byte actually transfers.
//
// Ports:
//   clock, resetn  clock / async active-low reset
//   clr            restart packing: idx=0, word=0
//   shift_en       store byte_in at lane idx and advance idx
//   byte_in        incoming byte
//   idx            next byte lane (0..3)
//   word           packed word
//   last           the next accepted byte completes the word (idx==3)
module byte_packer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [1:0]  idx,
  output logic [31:0] word,
  output logic        last
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (clr) begin
      idx  <= 2'd0;
      word <= 32'd0;
    end else if (shift_en) begin
      word[8*idx +: 8] <= byte_in;
      // Two-bit index wraps 3 -> 0 naturally, ready for the next word.
      idx <= idx + 2'd1;
    end
  end

  assign last = (idx == 2'd3);

endmodule

// File: rtl/pipeimem_loader.sv
// Purpose: writes a byte-streamed program into imem as packed words at addresses 0..count-1, holding the CPU in reset until done.
// Latency: 4th byte of a word accepted at edge N -> imem_we high for cycle N..N+1; next byte accepted at N+2 earliest (1 word / 5 cycles).
// Backpressure: byte_ready is high only in RECV; the source must hold byte_in/byte_valid otherwise.
//
// Ports:
//   clock, resetn         clock / async active-low reset
//   start, word_count     load request (sampled in IDLE/DONE) and word count
//   byte_in/valid/ready   program byte stream, transfers on valid&ready
//   imem_we/addr/wdata    imem write port, one we pulse per word
//   busy, done, err       status; err is sticky until a valid start
//   cpu_resetn            CPU reset, released only in DONE
module pipeimem_loader
  import pipeimem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_AW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_resetn
);

  // DEPTH expressed in the count width so the range check stays width-matched.
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic              err_r;

  logic              start_seen;
  logic              count_ok;
  logic              load_go;
  logic              pk_shift;
  logic [1:0]        pk_idx;
  logic [31:0]       pk_word;
  logic              pk_last;
  logic              at_last_addr;
  logic              unused_idx;

  assign start_seen   = start && ((state == LD_IDLE) || (state == LD_DONE));
  assign count_ok     = (word_count != '0) && (word_count <= DEPTH_W);
  assign load_go      = start_seen && count_ok;
  assign pk_shift     = (state == LD_RECV) && byte_valid;
  // count >= 1 whenever a load is active, so count-1 never underflows here.
  assign at_last_addr = ({1'b0, addr} == (count - ONE_W));

  byte_packer u_packer (
    .clock    (clock),
    .resetn   (resetn),
    .clr      (load_go),
    .shift_en (pk_shift),
    .byte_in  (byte_in),
    .idx      (pk_idx),
    .word     (pk_word),
    .last     (pk_last)
  );

  // Word completion is signalled by pk_last; the raw lane index is not needed here.
  assign unused_idx = ^pk_idx;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= LD_IDLE;
      count <= '0;
      addr  <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        LD_IDLE, LD_DONE: begin
          if (start_seen) begin
            if (count_ok) begin
              count <= word_count;
              addr  <= '0;
              err_r <= 1'b0;
              state <= LD_RECV;
            end else begin
              // Bad count: flag it, keep state (done/cpu_resetn unaffected).
              err_r <= 1'b1;
            end
          end
        end
        LD_RECV: begin
          if (pk_shift && pk_last) begin
            state <= LD_WRITE;
          end
        end
        LD_WRITE: begin
          if (at_last_addr) begin
            // Address is left at the final word; it never wraps past DEPTH-1.
            state <= LD_DONE;
          end else begin
            addr  <= addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            state <= LD_RECV;
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

  assign byte_ready = (state == LD_RECV);
  assign imem_we    = (state == LD_WRITE);
  assign imem_addr  = addr;
  assign imem_wdata = pk_word;
  assign busy       = ld_busy(state);
  assign done       = (state == LD_DONE);
  assign err        = err_r;
  assign cpu_resetn = (state == LD_DONE);

endmodule

// File: tb/tb_pipeimem_loader.sv
// Purpose: self-checking bench for pipeimem_loader using an expected-write scoreboard.
// Latency: checks each imem write against the queue head as it appears.
// Backpressure: byte source holds each byte until byte_ready is seen.
module tb_pipeimem_loader;

  localparam int ADDR_W = 6;

  logic              clock = 1'b0;
  logic              resetn;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_resetn;

  int n_cmp = 0;
  int n_mis = 0;
  int we_cnt = 0;
  logic [37:0] sb_q[$];

  always #5 clock = ~clock;

  pipeimem_loader #(.ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_resetn (cpu_resetn)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard side: every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (resetn === 1'b1 && imem_we === 1'b1) begin
      logic [37:0] e;
      we_cnt++;
      chk("rdy_in_write", {31'd0, byte_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", {26'd0, imem_addr}, {26'd0, e[37:32]});
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // All driver tasks are entered and left at posedge+1.
  task automatic do_reset(input string tag);
    resetn = 1'b0;
    @(negedge clock);
    chk({tag, "_ready"},  {31'd0, byte_ready}, 32'd0);
    chk({tag, "_we"},     {31'd0, imem_we},    32'd0);
    chk({tag, "_busy"},   {31'd0, busy},       32'd0);
    chk({tag, "_done"},   {31'd0, done},       32'd0);
    chk({tag, "_err"},    {31'd0, err},        32'd0);
    chk({tag, "_cpurst"}, {31'd0, cpu_resetn}, 32'd0);
    chk({tag, "_addr"},   {26'd0, imem_addr},  32'd0);
    chk({tag, "_wdata"},  imem_wdata,          32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input int cnt);
    word_count = cnt[ADDR_W:0];
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) begin
      @(posedge clock);
      #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock);
      if (byte_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) chk("byte_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [31:0] w, input int gapmax);
    sb_q.push_back({a[5:0], w});
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = w[8*k +: 8];
      send_byte(b, (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clock);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, {31'd0, seen}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int base;
    resetn = 1'b0;
    start = 1'b0;
    word_count = '0;
    byte_in = 8'd0;
    byte_valid = 1'b0;
    #1;
    do_reset("rst0");

    // 1: single word, back-to-back bytes
    do_start(1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_cpurst_load", {31'd0, cpu_resetn}, 32'd0);
    base = we_cnt;
    load_word(0, 32'h12345678, 0);
    wait_done("t1", 50);
    chk("t1_cpurst", {31'd0, cpu_resetn}, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_we_cnt", we_cnt - base, 32'd1);

    // 2: three words with random valid gaps
    do_start(3);
    base = we_cnt;
    for (int w = 0; w < 3; w++) load_word(w, $urandom, 3);
    wait_done("t2", 100);
    chk("t2_we_cnt", we_cnt - base, 32'd3);

    // 3: illegal counts from IDLE, then a legal one
    do_reset("rst3");
    base = we_cnt;
    do_start(0);
    chk("t3a_err", {31'd0, err}, 32'd1);
    chk("t3a_busy", {31'd0, busy}, 32'd0);
    chk("t3a_done", {31'd0, done}, 32'd0);
    chk("t3a_ready", {31'd0, byte_ready}, 32'd0);
    do_start(65);
    chk("t3b_err", {31'd0, err}, 32'd1);
    chk("t3b_busy", {31'd0, busy}, 32'd0);
    chk("t3b_cpurst", {31'd0, cpu_resetn}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("t3_no_we", we_cnt - base, 32'd0);
    do_start(2);
    chk("t3c_err_clr", {31'd0, err}, 32'd0);
    chk("t3c_busy", {31'd0, busy}, 32'd1);
    for (int w = 0; w < 2; w++) load_word(w, $urandom, 1);
    wait_done("t3", 100);
    chk("t3_we_cnt", we_cnt - base, 32'd2);

    // 4: full-depth load, last address 63 with no wrap
    do_start(64);
    base = we_cnt;
    for (int w = 0; w < 64; w++) load_word(w, $urandom, 0);
    wait_done("t4", 1000);
    chk("t4_we_cnt", we_cnt - base, 32'd64);
    chk("t4_last_addr", {26'd0, imem_addr}, 32'd63);

    // 5: reset in the middle of a word, then a fresh load
    do_start(1);
    send_byte(8'hEE, 0);
    send_byte(8'h99, 0);
    do_reset("rst5");
    do_start(1);
    load_word(0, 32'hDDCCBBAA, 1);
    wait_done("t5", 100);

    // 6: restart from DONE
    do_start(1);
    chk("t6_cpurst_fall", {31'd0, cpu_resetn}, 32'd0);
    chk("t6_done_clr", {31'd0, done}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd1);
    load_word(0, 32'hCAFEF00D, 2);
    wait_done("t6", 100);
    chk("t6_cpurst", {31'd0, cpu_resetn}, 32'd1);

    repeat (3) @(posedge clock);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
